timetag_inserter: RTL and testbench

Sits directly downstream of the 1 ms frontend timer and merges its time reference into the frontend event stream. Each `period_done` pulse snapshots the 48-bit `period` count and queues a two-word time-tag packet. The block inserts that packet into the outgoing 32-bit word stream only at event-packet boundaries, so the backend can attach coarse time to every event it receives. Event packets are never split or reordered.

---
 rtl/timetag_inserter.sv | 114 +++++++++++
 tb/tb_timetag_inserter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timetag_inserter.sv
// Merges 1 ms time-tag packets into the frontend event word stream,
// inserting tags only at event-packet boundaries.
module timetag_inserter #(
    parameter logic [15:0] MAX_DROP = 16'hFFFF,
    parameter logic [15:0] TAG_HDR  = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] period,
    input  logic        period_done,
    input  logic        tag_en,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        out_is_tag,
    input  logic        out_ready,
    output logic [15:0] drop_count
);

    // state | meaning
    // IDLE  | at a packet boundary; a pending tag wins over a new event
    // EVT   | inside an event packet; only event words are accepted
    // TAG0  | tag word 0 held in the output register
    // TAG1  | tag word 1 held in the output register
    typedef enum logic [1:0] {IDLE, EVT, TAG0, TAG1} state_t;

    state_t      state;
    logic        pend;
    logic [47:0] pend_period;
    logic [31:0] tag_lo;
    logic        out_free;
    logic        accept;
    logic        consume;

    assign out_free = !out_valid || out_ready;
    assign in_ready = !rst && out_free && ((state == IDLE && !pend) || state == EVT);
    assign accept   = in_valid && in_ready;
    assign consume  = (state == IDLE) && pend && out_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= 1'b0;
            pend_period <= '0;
            tag_lo      <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_is_tag  <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (consume) begin
                        out_data   <= {TAG_HDR, pend_period[47:32]};
                        out_valid  <= 1'b1;
                        out_last   <= 1'b0;
                        out_is_tag <= 1'b1;
                        // word 1 is latched now so a newer pending tag cannot corrupt it
                        tag_lo     <= pend_period[31:0];
                        state      <= TAG0;
                    end else if (accept) begin
                        out_data   <= in_data;
                        out_valid  <= 1'b1;
                        out_last   <= in_last;
                        out_is_tag <= 1'b0;
                        state      <= in_last ? IDLE : EVT;
                    end
                end
                EVT: begin
                    if (accept) begin
                        out_data   <= in_data;
                        out_valid  <= 1'b1;
                        out_last   <= in_last;
                        out_is_tag <= 1'b0;
                        if (in_last)
                            state <= IDLE;
                    end
                end
                TAG0: begin
                    if (out_ready) begin
                        out_data   <= tag_lo;
                        out_valid  <= 1'b1;
                        out_last   <= 1'b1;
                        out_is_tag <= 1'b1;
                        state      <= TAG1;
                    end
                end
                TAG1: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (period_done && tag_en) begin
                pend_period <= period;
                pend        <= 1'b1;
                if (pend && !consume && drop_count < MAX_DROP)
                    drop_count <= drop_count + 16'd1;
            end else if (consume) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timetag_inserter.sv
// Scoreboard bench for timetag_inserter: stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_timetag_inserter;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] period;
    logic        period_done;
    logic        tag_en;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_is_tag;
    logic        out_ready;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;
    logic [33:0] exp_q[$];

    timetag_inserter dut (
        .clk(clk), .rst(rst), .period(period), .period_done(period_done),
        .tag_en(tag_en), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .out_is_tag(out_is_tag), .out_ready(out_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h last=%b tag=%b expected none at %0t",
                         out_data, out_last, out_is_tag, $time);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("out_word", {14'd0, out_data, out_last, out_is_tag}, {14'd0, e});
            end
        end
        if (!rst && out_valid && out_is_tag)
            check("in_ready_during_tag", {47'd0, in_ready}, 48'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input logic [47:0] p);
        exp_q.push_back({16'hFF00, p[47:32], 1'b0, 1'b1});
        exp_q.push_back({p[31:0], 1'b1, 1'b1});
    endtask

    task automatic pulse(input logic [47:0] p);
        period      = p;
        period_done = 1'b1;
        tick();
        period_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end else begin
            exp_q.push_back({d, l, 1'b0});
        end
        tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            tick();
        end
        check(name, 48'(exp_q.size()), 48'd0);
        tick();
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("out_valid_timeout", {47'd0, out_valid}, 48'd1);
        tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; period = '0; period_done = 1'b0; tag_en = 1'b1;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", {47'd0, in_ready}, 48'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {47'd0, out_valid}, 48'd0);
        check("rst_out_last", {47'd0, out_last}, 48'd0);
        check("rst_out_is_tag", {47'd0, out_is_tag}, 48'd0);
        check("rst_out_data", {16'd0, out_data}, 48'd0);
        check("rst_drop_count", {32'd0, drop_count}, 48'd0);
        tick();

        // idle insertion with exact latency
        pulse(48'h0000_5678_9ABC);
        push_tag(48'h0000_5678_9ABC);
        @(negedge clk);
        check("lat_t1_valid", {47'd0, out_valid}, 48'd0);
        @(negedge clk);
        check("lat_t2_word0", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 32'hFF00_0000});
        @(negedge clk);
        check("lat_t3_word1", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 32'h5678_9ABC});
        tick();
        drain("idle_drain");

        // tag waits for packet boundary
        send_word(32'hA000_0000, 1'b0);
        send_word(32'hA000_0001, 1'b0);
        fork pulse(48'h0000_0000_0077); join_none
        send_word(32'hA000_0002, 1'b0);
        send_word(32'hA000_0003, 1'b1);
        in_valid = 1'b0;
        push_tag(48'h0000_0000_0077);
        drain("boundary_drain");

        // backpressure during TAG0
        out_ready = 1'b0;
        pulse(48'h00AB_1111_2222);
        push_tag(48'h00AB_1111_2222);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 32'hFF00_00AB});
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_word1", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 32'h1111_2222});
        tick();
        drain("bp_drain");

        // overwrite inside a long packet
        for (int i = 0; i < 3000; i++) begin
            if (i == 100)  fork pulse(48'd5); join_none
            if (i == 1000) fork pulse(48'd6); join_none
            send_word(32'(i), i == 2999);
        end
        in_valid = 1'b0;
        push_tag(48'd6);
        drain("ovw_drain");
        check("ovw_drop_count", {32'd0, drop_count}, 48'd1);

        // disabled tagging
        tag_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse(48'd99);
            tick();
        end
        repeat (10) tick();
        check("dis_drop_count", {32'd0, drop_count}, 48'd1);
        tag_en = 1'b1;

        // saturation while stuck inside a packet
        send_word(32'hCAFE_0000, 1'b0);
        in_valid = 1'b0;
        period = 48'h0000_0000_1000;
        period_done = 1'b1;
        repeat (65540) tick();
        period = 48'h4242_0000_0099;
        tick();
        period_done = 1'b0;
        @(negedge clk);
        check("sat_drop_count", {32'd0, drop_count}, 48'h00_0000_FFFF);
        tick();
        send_word(32'hCAFE_0001, 1'b1);
        in_valid = 1'b0;
        push_tag(48'h4242_0000_0099);
        drain("sat_drain");

        // reset while in TAG1 with a tag pending
        out_ready = 1'b0;
        pulse(48'h0001_0000_0001);
        exp_q.push_back({32'hFF00_0001, 1'b0, 1'b1});
        wait_out_valid();
        pulse(48'h0002_0000_0002);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", {47'd0, out_valid}, 48'd0);
        check("rst_mid_drop", {32'd0, drop_count}, 48'd0);
        tick();
        out_ready = 1'b1;
        repeat (20) tick();
        pulse(48'h0003_0000_0003);
        push_tag(48'h0003_0000_0003);
        drain("rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
